// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD countdown display path.
// Holds the digit width, the timer state encoding, default wrap values and digit clamping.
package countdown_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [15:0] DIGIT_MAX_MMSS = 16'h5959;
  localparam logic [7:0]  DIGIT_MAX_SS   = 8'h59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Non-BCD codes are larger than any legal max, so they clamp as well.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                      input logic [DIGIT_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with borrow chain and synchronous load.
// Latency: 1 cycle from en/load to q; backpressure: none (enable-driven).
module bcd_digit_down
  import countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic               borrow_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en && borrow_in) begin
      q_d = (q_q == '0) ? MAX : (q_q - DIGIT_W'(1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign is_zero    = (q_q == '0);
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with load/start/pause, optional auto-reload and done pulse.
// Latency: 1 cycle from any control input to bcd/state; backpressure: none (tick is a pulse).
module bcd_countdown_timer
  import countdown_pkg::*;
#(
  parameter int                            NUM_DIGITS  = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MAX   = DIGIT_MAX_MMSS,
  parameter bit                            AUTO_RELOAD = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  input  logic                          start,
  input  logic                          pause,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic                          zero,
  output logic                          running,
  output logic                          done
);

  localparam int BW = DIGIT_W * NUM_DIGITS;

  state_t          state_q, state_d;
  logic [BW-1:0]   reload_q, reload_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  logic [BW-1:0]         bcd_w;
  logic [BW-1:0]         ld_clamped;
  logic [BW-1:0]         dig_load_val;
  logic                  dig_load;
  logic                  dig_en;
  logic [NUM_DIGITS-1:0] dig_zero;
  logic [NUM_DIGITS:0]   borrow;
  logic                  zero_w;
  logic                  will_zero;

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_down #(
        .MAX(DIGIT_MAX[DIGIT_W*gi +: DIGIT_W])
      ) u_digit (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (dig_en),
        .borrow_in  (borrow[gi]),
        .load       (dig_load),
        .load_val   (dig_load_val[DIGIT_W*gi +: DIGIT_W]),
        .q          (bcd_w[DIGIT_W*gi +: DIGIT_W]),
        .is_zero    (dig_zero[gi]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  // The borrow out of the top digit is exactly "all digits zero".
  assign zero_w    = borrow[NUM_DIGITS];
  assign will_zero = (bcd_w[DIGIT_W-1:0] == DIGIT_W'(1)) && (&(dig_zero | NUM_DIGITS'(1)));

  always_comb begin
    ld_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ld_clamped[DIGIT_W*i +: DIGIT_W] = clamp_digit(load_value[DIGIT_W*i +: DIGIT_W],
                                                     DIGIT_MAX[DIGIT_W*i +: DIGIT_W]);
    end
  end

  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    done_d       = 1'b0;
    dig_load     = 1'b0;
    dig_load_val = reload_q;
    dig_en       = 1'b0;

    if (load) begin
      dig_load     = 1'b1;
      dig_load_val = ld_clamped;
      reload_d     = ld_clamped;
      state_d      = IDLE;
    end else if (pause) begin
      if (state_q == RUN) state_d = PAUSED;
    end else if (start && (state_q != RUN)) begin
      case (state_q)
        IDLE, PAUSED: begin
          if (!zero_w) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            done_d  = ~done_q;
          end
        end
        DONE: begin
          if (reload_q != '0) begin
            dig_load = 1'b1;
            state_d  = RUN;
          end else begin
            done_d = ~done_q;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tick && (state_q == RUN)) begin
      if (!zero_w) begin
        dig_en = 1'b1;
        if (will_zero) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) state_d = DONE;
        end
      end else if (reload_q != '0) begin
        // Only reachable with auto-reload: the tick after zero restarts the period.
        dig_load = 1'b1;
      end else begin
        state_d = DONE;
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bcd     = bcd_w;
  assign zero    = zero_w;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one stop-at-zero and one auto-reload instance share stimulus.
module tb_bcd_countdown_timer;
  import countdown_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;

  logic [15:0] bcd0, bcd1;
  logic        zero0, zero1, running0, running1, done0, done1;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  always #5 clock = ~clock;

  bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959), .AUTO_RELOAD(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .bcd(bcd0), .zero(zero0), .running(running0), .done(done0)
  );

  bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959), .AUTO_RELOAD(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .bcd(bcd1), .zero(zero1), .running(running1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 ns after the edge, then return inputs to idle.
  task automatic cyc(input logic t, input logic l, input logic s, input logic p,
                     input logic [15:0] lv);
    tick = t; load = l; start = s; pause = p; load_value = lv;
    @(posedge clock);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  function automatic logic [15:0] mmss(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    // Reset values
    #3;
    chk("rst_bcd", 32'(bcd0), 32'h0);
    chk("rst_zero", 32'(zero0), 32'h1);
    chk("rst_running", 32'(running0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;

    // 1:02 countdown to zero, one tick per cycle
    cyc(0, 1, 0, 0, 16'h0102);
    chk("t1_load", 32'(bcd0), 32'h0102);
    chk("t1_load_state", 32'(dut0.state_q), 32'(IDLE));
    cyc(0, 0, 1, 0, 16'h0);
    chk("t1_running", 32'(running0), 32'h1);
    done_cnt = 0;
    for (int k = 1; k <= 62; k++) begin
      cyc(1, 0, 0, 0, 16'h0);
      if (done0) done_cnt++;
      chk($sformatf("t1_bcd_%0d", k), 32'(bcd0), 32'(mmss(62 - k)));
    end
    chk("t1_done_at_zero", 32'(done0), 32'h1);
    chk("t1_done_count", 32'(done_cnt), 32'h1);
    chk("t1_state_done", 32'(dut0.state_q), 32'(DONE));
    chk("t1_not_running", 32'(running0), 32'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t1_done_cleared", 32'(done0), 32'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t1_hold_zero", 32'(bcd0), 32'h0);
    chk("t1_zero_flag", 32'(zero0), 32'h1);

    // Pause/resume
    cyc(0, 1, 0, 0, 16'h0010);
    cyc(0, 0, 1, 0, 16'h0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 16'h0);
    chk("t2_after5", 32'(bcd0), 32'h0005);
    cyc(0, 0, 0, 1, 16'h0);
    chk("t2_paused", 32'(dut0.state_q), 32'(PAUSED));
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 16'h0);
    chk("t2_hold", 32'(bcd0), 32'h0005);
    cyc(0, 0, 1, 0, 16'h0);
    chk("t2_resume", 32'(running0), 32'h1);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 16'h0);
    chk("t2_at1", 32'(bcd0), 32'h0001);
    chk("t2_no_early_done", 32'(done0), 32'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t2_final", 32'(bcd0), 32'h0000);
    chk("t2_done", 32'(done0), 32'h1);

    // Auto-reload period of L+1 ticks
    begin
      logic [15:0] exp_seq [8];
      logic        exp_done [8];
      exp_seq  = '{16'h0002, 16'h0001, 16'h0000, 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h0003};
      exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      cyc(0, 1, 0, 0, 16'h0003);
      cyc(0, 0, 1, 0, 16'h0);
      for (int k = 0; k < 8; k++) begin
        cyc(1, 0, 0, 0, 16'h0);
        chk($sformatf("t3_bcd_%0d", k), 32'(bcd1), 32'(exp_seq[k]));
        chk($sformatf("t3_done_%0d", k), 32'(done1), 32'(exp_done[k]));
      end
      chk("t3_still_running", 32'(running1), 32'h1);
    end

    // Clamping and start from zero
    cyc(0, 1, 0, 0, 16'h9A7F);
    chk("t4_clamp", 32'(bcd0), 32'h5959);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0);
    chk("t4_zero_start_state", 32'(dut0.state_q), 32'(DONE));
    chk("t4_zero_start_done", 32'(done0), 32'h1);
    cyc(0, 0, 0, 0, 16'h0);
    chk("t4_done_single", 32'(done0), 32'h0);

    // Same-cycle priorities
    cyc(0, 1, 0, 0, 16'h0050);
    cyc(0, 0, 1, 0, 16'h0);
    cyc(1, 0, 0, 1, 16'h0);
    chk("t5_tick_pause_bcd", 32'(bcd0), 32'h0050);
    chk("t5_tick_pause_state", 32'(dut0.state_q), 32'(PAUSED));
    cyc(0, 0, 1, 0, 16'h0);
    cyc(1, 1, 0, 0, 16'h0042);
    chk("t5_tick_load_bcd", 32'(bcd0), 32'h0042);
    chk("t5_tick_load_state", 32'(dut0.state_q), 32'(IDLE));
    chk("t5_tick_load_nodone", 32'(done0), 32'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t5_idle_tick_ignored", 32'(bcd0), 32'h0042);
    cyc(0, 0, 1, 1, 16'h0);
    chk("t5_start_pause_state", 32'(dut0.state_q), 32'(IDLE));
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 16'h0);
    chk("t5_run_start_pause", 32'(dut0.state_q), 32'(PAUSED));

    // Asynchronous reset between edges while running
    cyc(0, 1, 0, 0, 16'h0102);
    cyc(0, 0, 1, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t6_pre_reset", 32'(bcd0), 32'h0100);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_bcd", 32'(bcd0), 32'h0);
    chk("t6_rst_running", 32'(running0), 32'h0);
    chk("t6_rst_done", 32'(done0), 32'h0);
    chk("t6_rst_state", 32'(dut0.state_q), 32'(IDLE));
    chk("t6_rst_reload", 32'(dut0.reload_q), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t6_post_reset_idle", 32'(bcd0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
